commit_trace_buffer: RTL and testbench

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_buffer.sv | 110 +++++++++++
 tb/tb_commit_trace_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: show-ahead FIFO of GRF-write and DM-store commit events.
// Up to two events per cycle (GRF first); excess events are dropped and flagged.
module commit_trace_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grf_we,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_wdata,
    input  logic [31:0]              grf_pc,
    input  logic                     dm_we,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_wdata,
    input  logic [31:0]              dm_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_kind,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_addr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_F = (CW+1)'(DEPTH);

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         grf_entry;
    entry_t         dm_entry;
    entry_t         head;

    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  dm_slot;
    logic [CW:0]    free;
    logic [1:0]     push_cnt;
    logic           grf_ev;
    logic           dm_ev;
    logic           push_grf;
    logic           push_dm;
    logic           pop;
    logic           drop;

    assign grf_ev = grf_we && (grf_addr != 5'd0);
    assign dm_ev  = dm_we;

    assign grf_entry = '{kind: 1'b0, pc: grf_pc,
                         addr: {27'd0, grf_addr}, data: grf_wdata};
    assign dm_entry  = '{kind: 1'b1, pc: dm_pc,
                         addr: dm_addr, data: dm_wdata};

    assign out_valid = (count != '0);
    assign pop       = !reset && out_valid && out_ready;

    // A pop in the same cycle frees its slot for this cycle's events.
    assign free = DEPTH_F - {1'b0, count} + {{CW{1'b0}}, pop};

    // The DM event lands after the GRF event, so it needs one more free slot.
    assign push_grf = !reset && grf_ev && (free != '0);
    assign push_dm  = !reset && dm_ev && (free > {{CW{1'b0}}, push_grf});
    assign drop     = !reset && ((grf_ev && !push_grf) || (dm_ev && !push_dm));

    assign push_cnt = {1'b0, push_grf} + {1'b0, push_dm};
    assign dm_slot  = wr_ptr + AW'(push_grf);

    always_ff @(posedge clk) begin
        if (push_grf) mem[wr_ptr] <= grf_entry;
        if (push_dm)  mem[dm_slot] <= dm_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr + AW'(pop);
            wr_ptr   <= wr_ptr + AW'(push_cnt);
            count    <= count + CW'(push_cnt) - CW'(pop);
            overflow <= overflow || drop;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        out_kind = 1'b0;
        out_pc   = '0;
        out_addr = '0;
        out_data = '0;
        if (out_valid) begin
            out_kind = head.kind;
            out_pc   = head.pc;
            out_addr = head.addr;
            out_data = head.data;
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer (DEPTH = 8).
// Each task drives one scenario and checks the outputs against hand values.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wdata;
    logic [31:0] grf_pc;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_pc;
    logic        out_valid;
    logic        out_ready;
    logic        out_kind;
    logic [31:0] out_pc;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;

    logic        exp_kind [$];
    logic [31:0] exp_data [$];

    commit_trace_buffer #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_addr(grf_addr),
        .grf_wdata(grf_wdata), .grf_pc(grf_pc),
        .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_pc(dm_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_pc(out_pc),
        .out_addr(out_addr), .out_data(out_data),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; grf_we = 0; grf_addr = 0; grf_wdata = 0; grf_pc = 0;
        dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_pc = 0; out_ready = 0;
    endtask

    task automatic set_grf(input logic [4:0] a, input logic [31:0] d,
                           input logic [31:0] p);
        grf_we = 1; grf_addr = a; grf_wdata = d; grf_pc = p;
    endtask

    task automatic set_dm(input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] p);
        dm_we = 1; dm_addr = a; dm_wdata = d; dm_pc = p;
    endtask

    task automatic pop_one();
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_reset();
        idle(); reset = 1; tick(); reset = 0;
        vectors++;
        if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got count=%0d valid=%b ovf=%b want 0/0/0",
                     count, out_valid, overflow);
        end
        vectors++;
        if (out_kind !== 1'b0 || out_pc !== 0 || out_addr !== 0 || out_data !== 0) begin
            miscompares++;
            $display("FAIL reset_data got kind=%b pc=%h addr=%h data=%h want zeros",
                     out_kind, out_pc, out_addr, out_data);
        end
    endtask

    task automatic test_single_grf();
        idle(); set_grf(5'd5, 32'h1234, 32'h3000); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_latency got valid=%b want 0", out_valid);
        end
        tick(); idle();
        vectors++;
        if (out_valid !== 1'b1 || out_kind !== 1'b0 || count !== 4'd1) begin
            miscompares++;
            $display("FAIL single_ctrl got valid=%b kind=%b count=%0d want 1/0/1",
                     out_valid, out_kind, count);
        end
        vectors++;
        if (out_addr !== 32'h5 || out_data !== 32'h1234 || out_pc !== 32'h3000) begin
            miscompares++;
            $display("FAIL single_data got addr=%h data=%h pc=%h want 5/1234/3000",
                     out_addr, out_data, out_pc);
        end
        pop_one();
        vectors++;
        if (count !== 4'd0 || out_valid !== 1'b0 || out_data !== 0) begin
            miscompares++;
            $display("FAIL single_pop got count=%0d valid=%b data=%h want 0/0/0",
                     count, out_valid, out_data);
        end
        out_ready = 1; tick(); out_ready = 0;
        vectors++;
        if (count !== 4'd0) begin
            miscompares++;
            $display("FAIL empty_ready got count=%0d want 0", count);
        end
    endtask

    task automatic test_dual();
        idle();
        set_grf(5'd8, 32'hAAAA, 32'h3004);
        set_dm(32'h10, 32'hFF, 32'h3008);
        tick(); idle();
        vectors++;
        if (count !== 4'd2 || out_kind !== 1'b0 || out_addr !== 32'h8 ||
            out_pc !== 32'h3004 || out_data !== 32'hAAAA) begin
            miscompares++;
            $display("FAIL dual_first got count=%0d kind=%b addr=%h pc=%h data=%h want 2/0/8/3004/aaaa",
                     count, out_kind, out_addr, out_pc, out_data);
        end
        pop_one();
        vectors++;
        if (count !== 4'd1 || out_kind !== 1'b1 || out_addr !== 32'h10 ||
            out_pc !== 32'h3008 || out_data !== 32'hFF) begin
            miscompares++;
            $display("FAIL dual_second got count=%0d kind=%b addr=%h pc=%h data=%h want 1/1/10/3008/ff",
                     count, out_kind, out_addr, out_pc, out_data);
        end
        pop_one();
        vectors++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL dual_drain got count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_zero_filter();
        idle(); set_grf(5'd0, 32'hBEEF, 32'h3010);
        tick(); idle();
        vectors++;
        if (count !== 4'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_filter got count=%0d ovf=%b valid=%b want 0/0/0",
                     count, overflow, out_valid);
        end
    endtask

    task automatic test_overflow();
        idle();
        for (int i = 1; i <= 7; i++) begin
            set_grf(5'(i), 32'h100 + i, 32'h4000 + 4 * i);
            tick();
        end
        idle();
        vectors++;
        if (count !== 4'd7 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_fill got count=%0d ovf=%b want 7/0", count, overflow);
        end
        set_grf(5'd8, 32'h108, 32'h4020);
        set_dm(32'h200, 32'hDEAD, 32'h4024);
        tick(); idle();
        vectors++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set got count=%0d ovf=%b want 8/1", count, overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if (out_kind !== 1'b0 || out_addr !== 32'(i) || out_data !== 32'h100 + i) begin
                miscompares++;
                $display("FAIL ovf_drain%0d got kind=%b addr=%h data=%h want 0/%h/%h",
                         i, out_kind, out_addr, out_data, i, 32'h100 + i);
            end
            pop_one();
        end
        vectors++;
        if (count !== 4'd0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky got count=%0d ovf=%b want 0/1", count, overflow);
        end
        reset = 1; tick(); reset = 0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear got ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_full_pop_wrap();
        logic [31:0] d;
        idle();
        exp_kind.delete(); exp_data.delete();
        for (int i = 0; i < 8; i++) begin
            set_dm(32'h1000 + i, 32'h5000 + i, 32'h6000 + 4 * i);
            exp_kind.push_back(1'b1); exp_data.push_back(32'h5000 + i);
            tick();
        end
        idle();
        vectors++;
        if (count !== 4'd8) begin
            miscompares++;
            $display("FAIL full_fill got count=%0d want 8", count);
        end
        out_ready = 1; set_grf(5'd9, 32'h9999, 32'h7000);
        exp_kind.push_back(1'b0); exp_data.push_back(32'h9999);
        void'(exp_kind.pop_front()); void'(exp_data.pop_front());
        tick(); idle();
        vectors++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop got count=%0d ovf=%b want 8/0", count, overflow);
        end
        for (int i = 0; i < 20; i++) begin
            d = 32'hA000 + i;
            vectors++;
            if (out_kind !== exp_kind[0] || out_data !== exp_data[0]) begin
                miscompares++;
                $display("FAIL wrap_head%0d got kind=%b data=%h want %b/%h",
                         i, out_kind, out_data, exp_kind[0], exp_data[0]);
            end
            out_ready = 1; set_dm(32'h2000 + i, d, 32'h8000 + 4 * i);
            exp_kind.push_back(1'b1); exp_data.push_back(d);
            void'(exp_kind.pop_front()); void'(exp_data.pop_front());
            tick(); idle();
        end
        vectors++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_count got count=%0d ovf=%b want 8/0", count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (out_kind !== exp_kind[0] || out_data !== exp_data[0]) begin
                miscompares++;
                $display("FAIL wrap_drain%0d got kind=%b data=%h want %b/%h",
                         i, out_kind, out_data, exp_kind[0], exp_data[0]);
            end
            void'(exp_kind.pop_front()); void'(exp_data.pop_front());
            pop_one();
        end
        vectors++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_empty got count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        idle();
        for (int i = 1; i <= 5; i++) begin
            set_grf(5'(i + 10), 32'hC000 + i, 32'h9000 + 4 * i);
            tick();
        end
        idle();
        vectors++;
        if (count !== 4'd5) begin
            miscompares++;
            $display("FAIL mid_fill got count=%0d want 5", count);
        end
        reset = 1; out_ready = 1;
        set_dm(32'h300, 32'h77, 32'h9100);
        tick(); idle();
        vectors++;
        if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 0) begin
            miscompares++;
            $display("FAIL mid_reset got count=%0d valid=%b ovf=%b data=%h want 0/0/0/0",
                     count, out_valid, overflow, out_data);
        end
        tick();
        vectors++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_after got count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_single_grf();
        test_dual();
        test_zero_filter();
        test_overflow();
        test_full_pop_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
